// File: rtl/tx_mac_arb_pkg.sv
// Shared types, constants and the round-robin selection function for the TX MAC arbiter.
package tx_mac_arb_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    GRANT = 3'd1,
    ABORT = 3'd2,
    DRAIN = 3'd3,
    GAP   = 3'd4
  } arb_state_t;

  localparam logic [7:0] ABORT_BYTE = 8'h00;

  // Requests are zero-extended to 8, so wrapping mod 8 matches wrapping mod NUM_SRC.
  function automatic logic [2:0] rr_select(input logic [7:0] req, input logic [2:0] ptr);
    logic [2:0] idx;
    logic       found;
    rr_select = ptr;
    found     = 1'b0;
    for (int i = 0; i < 8; i++) begin
      idx = ptr + 3'(i);
      if (!found && req[idx]) begin
        rr_select = idx;
        found     = 1'b1;
      end else begin
        found = found;
      end
    end
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational next-winner selector; TX_ARB_STRICT_PRIO_EN switches it to fixed lowest-index priority.
module rr_arbiter
  import tx_mac_arb_pkg::*;
#(
  parameter int NUM_SRC = 2
) (
  input  logic [NUM_SRC-1:0]         req,
  input  logic [$clog2(NUM_SRC)-1:0] ptr,
  output logic [$clog2(NUM_SRC)-1:0] winner
);

  localparam int IW = $clog2(NUM_SRC);

  logic [7:0] req_ext_s;
  logic [2:0] ptr_ext_s;

  assign req_ext_s = 8'(req);
  assign ptr_ext_s = 3'(ptr);

`ifdef TX_ARB_STRICT_PRIO_EN
  logic unused_ptr_s;
  assign unused_ptr_s = ^ptr_ext_s;
  assign winner       = IW'(rr_select(req_ext_s, 3'd0));
`else
  assign winner       = IW'(rr_select(req_ext_s, ptr_ext_s));
`endif

endmodule

// File: rtl/tx_mac_arbiter.sv
// Packet-granular arbiter feeding one TX MAC AXI-Stream from NUM_SRC sources, with IFG and stall abort.
// TX_ARB_STRICT_PRIO_EN selects fixed priority instead of round-robin (no rr pointer then).
module tx_mac_arbiter
  import tx_mac_arb_pkg::*;
#(
  parameter int NUM_SRC        = 2,
  parameter int IFG_CYCLES     = 12,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [8*NUM_SRC-1:0]         s_axis_tdata,
  input  logic [NUM_SRC-1:0]           s_axis_tvalid,
  input  logic [NUM_SRC-1:0]           s_axis_tlast,
  output logic [NUM_SRC-1:0]           s_axis_tready,
  output logic [7:0]                   m_tx_axis_tdata,
  output logic                         m_tx_axis_tvalid,
  output logic                         m_tx_axis_tlast,
  output logic                         m_tx_axis_tuser,
  input  logic                         m_tx_axis_trdy,
  output logic [$clog2(NUM_SRC)-1:0]   grant_idx,
  output logic                         busy
);

  localparam int IW = $clog2(NUM_SRC);
  localparam int GW = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES) : 1;
  localparam int SW = $clog2(TIMEOUT_CYCLES);
  localparam logic [GW-1:0] GAP_LOAD  = GW'((IFG_CYCLES > 0) ? IFG_CYCLES - 1 : 0);
  localparam logic [SW-1:0] STALL_MAX = SW'(TIMEOUT_CYCLES - 1);
  localparam arb_state_t    END_STATE = (IFG_CYCLES > 0) ? GAP : IDLE;

  arb_state_t    state_r, state_nxt_s;
  logic [IW-1:0] grant_r, grant_nxt_s;
  logic [SW-1:0] stall_r, stall_nxt_s;
  logic [GW-1:0] gap_r, gap_nxt_s;
  logic [IW-1:0] ptr_s, winner_s;
  logic          frame_done_s;
  logic [7:0]    src_data_s;
  logic          src_valid_s, src_last_s;

  assign src_data_s  = s_axis_tdata[int'(grant_r)*8 +: 8];
  assign src_valid_s = s_axis_tvalid[grant_r];
  assign src_last_s  = s_axis_tlast[grant_r];

`ifdef TX_ARB_STRICT_PRIO_EN
  logic unused_done_s;
  assign unused_done_s = frame_done_s;
  assign ptr_s         = {IW{1'b0}};
`else
  localparam logic [IW-1:0] LAST_SRC = IW'(NUM_SRC - 1);
  logic [IW-1:0] rr_r;
  assign ptr_s = rr_r;

  // Round-robin pointer: points just past the source whose frame last completed.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rr_r <= {IW{1'b0}};
    end else if (frame_done_s) begin
      rr_r <= (grant_r == LAST_SRC) ? {IW{1'b0}} : grant_r + IW'(1);
    end else begin
      rr_r <= rr_r;
    end
  end
`endif

  rr_arbiter #(
    .NUM_SRC (NUM_SRC)
  ) u_rr_arbiter (
    .req    (s_axis_tvalid),
    .ptr    (ptr_s),
    .winner (winner_s)
  );

  // FSM and counter registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_r <= IDLE;
      grant_r <= {IW{1'b0}};
      stall_r <= {SW{1'b0}};
      gap_r   <= {GW{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      grant_r <= grant_nxt_s;
      stall_r <= stall_nxt_s;
      gap_r   <= gap_nxt_s;
    end
  end

  // Next-state, counters and the stream multiplexer; GRANT is a zero-latency passthrough.
  always_comb begin
    state_nxt_s      = state_r;
    grant_nxt_s      = grant_r;
    stall_nxt_s      = {SW{1'b0}};
    gap_nxt_s        = gap_r;
    frame_done_s     = 1'b0;
    m_tx_axis_tdata  = 8'h00;
    m_tx_axis_tvalid = 1'b0;
    m_tx_axis_tlast  = 1'b0;
    m_tx_axis_tuser  = 1'b0;
    s_axis_tready    = {NUM_SRC{1'b0}};
    case (state_r)
      IDLE: begin
        if (|s_axis_tvalid) begin
          grant_nxt_s = winner_s;
          state_nxt_s = GRANT;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      GRANT: begin
        m_tx_axis_tdata          = src_data_s;
        m_tx_axis_tvalid         = src_valid_s;
        m_tx_axis_tlast          = src_last_s;
        s_axis_tready[grant_r]   = m_tx_axis_trdy;
        // Stall counting looks only at tvalid so paced trdy never causes an abort.
        if (src_valid_s) begin
          if (m_tx_axis_trdy && src_last_s) begin
            frame_done_s = 1'b1;
            gap_nxt_s    = GAP_LOAD;
            state_nxt_s  = END_STATE;
          end else begin
            state_nxt_s  = GRANT;
          end
        end else if (stall_r == STALL_MAX) begin
          state_nxt_s = ABORT;
        end else begin
          stall_nxt_s = stall_r + SW'(1);
        end
      end
      ABORT: begin
        m_tx_axis_tdata  = ABORT_BYTE;
        m_tx_axis_tvalid = 1'b1;
        m_tx_axis_tlast  = 1'b1;
        m_tx_axis_tuser  = 1'b1;
        if (m_tx_axis_trdy) begin
          state_nxt_s = DRAIN;
        end else begin
          state_nxt_s = ABORT;
        end
      end
      DRAIN: begin
        s_axis_tready[grant_r] = 1'b1;
        if (src_valid_s && src_last_s) begin
          frame_done_s = 1'b1;
          gap_nxt_s    = GAP_LOAD;
          state_nxt_s  = END_STATE;
        end else begin
          state_nxt_s  = DRAIN;
        end
      end
      GAP: begin
        if (gap_r == {GW{1'b0}}) begin
          state_nxt_s = IDLE;
        end else begin
          gap_nxt_s   = gap_r - GW'(1);
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  assign grant_idx = grant_r;
  assign busy      = (state_r != IDLE);

endmodule

// File: doc/tx_mac_arbiter.md
# tx_mac_arbiter

Packet-granular arbiter that shares the single TX MAC AXI-Stream input among `NUM_SRC` upstream FIFOs, for example UDP payload and ARP reply paths. It grants one source per frame using round-robin order and forwards that source's bytes unmodified to the TX MAC. After each frame it enforces a minimum idle gap. A granted source that stalls mid-frame is timed out: the arbiter aborts the frame towards the MAC and drains the rest of it from the source.

## Interface
- `NUM_SRC`, 2, number of requesters (2..8)
- `IFG_CYCLES`, 12, idle clocks inserted after each frame's tlast handshake (0 = no gap)
- `TIMEOUT_CYCLES`, 64, consecutive cycles of granted tvalid low mid-frame before abort (≥2)
- `clk`  in  1  system clock
- `reset_n`  in  1  synchronous, active-low reset
- `s_axis_tdata`  in  8*NUM_SRC  source bytes; source i occupies [8i+7:8i]
- `s_axis_tvalid`  in  NUM_SRC  per-source valid
- `s_axis_tlast`  in  NUM_SRC  per-source last byte of frame
- `s_axis_tready`  out  NUM_SRC  per-source ready
- `m_tx_axis_tdata`  out  8  byte to TX MAC
- `m_tx_axis_tvalid`  out  1  valid to TX MAC
- `m_tx_axis_tlast`  out  1  last byte to TX MAC
- `m_tx_axis_tuser`  out  1  frame abort/error flag, qualified by tlast
- `m_tx_axis_trdy`  in  1  TX MAC ready; it pulses per byte in MII mode
- `grant_idx`  out  $clog2(NUM_SRC)  currently or most recently granted source
- `busy`  out  1  high in any state other than IDLE

## Operation
- States: IDLE, GRANT, ABORT, DRAIN, GAP.
- **IDLE**
  - All `s_axis_tready` are 0 and `m_tx_axis_tvalid` is 0.
  - If any tvalid is high, pick the winner by searching from `rr_ptr` upward, wrapping to 0.
  - Register the winner into `grant_idx` and go to GRANT on the next cycle.
- **GRANT** (pure combinational passthrough)
  - m_tdata/m_tvalid/m_tlast come from the granted source.
  - `s_axis_tready[grant] = m_tx_axis_trdy`; all other readies are 0.
  - `m_tx_axis_tuser` is 0.
  - A beat transfers when both tvalid and trdy are high.
  - On a beat with tlast: set `rr_ptr = grant+1` (wrapping mod NUM_SRC), then go to GAP if IFG_CYCLES>0, otherwise IDLE.
- **Timeout**
  - In GRANT, `stall_cnt` increments each cycle the granted tvalid is low.
  - It clears on any cycle the granted tvalid is high.
  - When it reaches TIMEOUT_CYCLES-1 while tvalid is still low, go to ABORT.
- **ABORT**
  - Drive `m_tx_axis_tvalid=1`, `tlast=1`, `tuser=1`, `tdata=8'h00`.
  - All source readies are 0.
  - Hold until trdy is high, then go to DRAIN.
- **DRAIN**
  - `s_axis_tready[grant]=1` and `m_tx_axis_tvalid=0`; accepted bytes are discarded.
  - When the granted source presents tvalid&tlast, go to GAP (or IDLE if IFG_CYCLES=0) and advance `rr_ptr`.
- **GAP**
  - Load `gap_cnt=IFG_CYCLES-1` on entry and decrement each cycle.
  - Go to IDLE on the cycle after the counter reaches 0.
  - Outputs are as in IDLE.
- Sources that are not granted are never readied. Their tvalid may stay high indefinitely without side effects.

## Timing
- Reset values:
  - state=IDLE, rr_ptr=0, grant_idx=0, stall_cnt=0, gap_cnt=0.
  - All outputs are 0.
  - Reset mid-frame truncates silently; no abort beat is emitted.
- Arbitration latency: 1 clock from a tvalid seen in IDLE to the first possible beat.
- Data path latency in GRANT: 0 cycles.
- Back-to-back frames from the same source: tlast beat, then IFG_CYCLES gap cycles, then 1 IDLE cycle, then the next first beat.
- If a source's tvalid falls on the same cycle arbitration samples it, the grant still stands. The timeout logic covers that case.
- The timeout counter ignores `m_tx_axis_trdy`, so MII trdy pulsing never triggers an abort.

## Configuration
- `TX_ARB_STRICT_PRIO_EN` defined:
  - IDLE selection is fixed priority, lowest index wins.
  - `rr_ptr` is not implemented.
- Undefined (default): round-robin as described above.

## Structure
- `tx_mac_arb_pkg`:
  - state enum `arb_state_t` {IDLE, GRANT, ABORT, DRAIN, GAP}.
  - `ABORT_BYTE = 8'h00`.
  - function `rr_select(req, ptr)` returning the winner index.
- One sub-module, `rr_arbiter`: a combinational next-winner selector from the request vector and pointer. The strict-priority variant is selected inside it by the macro.

## Test plan
- **Single source:** src0 sends a 64-byte frame with trdy held at 1 → 64 beats on m_, byte order preserved, tlast on beat 64, tuser=0, then 12 GAP cycles and busy drops.
- **Round-robin contention:** src0 and src1 continuously valid with 3 frames each → grant order 0,1,0,1,0,1, with an IFG of at least 12 cycles between frames. With `TX_ARB_STRICT_PRIO_EN`, the order is 0,0,0,1,1,1.
- **MII pacing:** trdy high 1 cycle in 2 for a 20-byte frame → exactly 20 beats, the source's tready mirrors trdy, and there is no timeout.
- **Stall timeout:** src1 drops tvalid after byte 10 for 64 cycles → one m_ beat with tdata=00, tlast=1, tuser=1. The remaining src1 bytes through its tlast are consumed with m_tvalid=0, then GAP.
- **Reset mid-frame:** reset_n low for 1 cycle at byte 5 → all outputs 0 the next cycle and state IDLE. A new frame from src0 afterwards is granted normally, with the first beat 1 cycle after IDLE.
